cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Parametrised run/step controller placed between the board clock and the MIPS core. It replaces fixed clk_ctrl0/clk_ctrl1 clock gating.
- Generates a per-cycle CPU clock enable.
- Modes: free-run, N-step, and run-to-breakpoint.
- Counts executed cycles.
- Used by both the FPGA top level and the CPU test bench to bring the core to a known PC.

Parameters:
PC_W, 8, width of CPU program counter
CNT_W, 32, width of executed-cycle counter
STEP_W, 16, width of step-count input
NBKPT, 2, number of PC breakpoints
TRACE_DEPTH, 8, PC trace entries (power of two; used only with optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
i_mode  in  2  00 halt, 01 free-run, 10 step-N, 11 run-to-breakpoint
i_go  in  1  start pulse; sampled each rising edge
i_step_n  in  STEP_W  cycle count for step-N, sampled on accepted go
i_stop  in  1  abort request
i_pc  in  PC_W  current CPU PC
i_bkpt_addr  in  NBKPT*PC_W  breakpoint addresses, entry k at [k*PC_W +: PC_W]
i_bkpt_en  in  NBKPT  per-breakpoint enable
i_trace_idx  in  $clog2(TRACE_DEPTH)  trace read index, 0 = most recent
o_cpu_en  out  1  CPU clock enable
o_busy  out  1  high in RUN
o_done  out  1  one-cycle completion pulse
o_hit  out  NBKPT  breakpoint(s) that ended the run; sticky
o_cycles  out  CNT_W  enabled cycles since last accepted go
o_state  out  2  00 IDLE, 01 RUN, 10 DONE
o_trace_pc  out  PC_W  traced PC at i_trace_idx

Behaviour:
- Reset (async, active-high): state IDLE; o_cpu_en=0, o_busy=0, o_done=0, o_hit=0, o_cycles=0, step counter=0, trace contents/pointer=0.
- Go acceptance: i_go is accepted only in IDLE. i_go in RUN or DONE is ignored.
- On an accepted go:
  - o_cycles and o_hit clear; the first_cycle flag sets.
  - Step counter loads i_step_n; a value of 0 is treated as 1.
  - Mode 00: go to DONE directly. o_cpu_en never rises; o_cycles stays 0.
  - Modes 01/10/11: go to RUN the next cycle.
- stop_cond is combinational in RUN:
  - i_stop; OR
  - mode 11 and any enabled breakpoint equals i_pc and not first_cycle; OR
  - mode 10 and step counter == 0.
- Mode is latched at go. Changes to i_mode during RUN have no effect.
- o_cpu_en = (state==RUN) && !stop_cond. Because it is combinational, the CPU never executes the cycle at a breakpoint PC.
- Each cycle with o_cpu_en=1:
  - o_cycles increments, saturating at all-ones.
  - Step counter decrements.
  - first_cycle clears.
- In RUN with stop_cond=1: go to DONE next edge. o_hit latches the match vector; a simultaneous i_stop still records the hit.
- DONE lasts exactly one cycle: o_done=1, o_cpu_en=0, then IDLE.
- Resume semantics: first_cycle suppresses the breakpoint match on the first RUN cycle, so a go from a breakpoint PC executes at least one cycle.
- Step-N with N=5 gives exactly 5 enable cycles, then the DONE pulse on cycle 7 after go.
- o_busy = (state==RUN).
- Reset mid-RUN: o_cpu_en drops asynchronously and all state clears.

Optional Feature:
CPU_RUN_TRACE_EN
- Defined: circular buffer of TRACE_DEPTH PCs.
  - Writes i_pc on every o_cpu_en cycle; the write pointer wraps.
  - o_trace_pc is a combinational read of entry (wptr-1-i_trace_idx) mod TRACE_DEPTH.
  - Entries not yet written read 0.
  - The buffer is not cleared on go, only by reset.
- Undefined: no storage is built; o_trace_pc is tied to 0. Ports are unchanged.

Decomposition:
- Package cpu_run_pkg:
  - mode encodings MODE_HALT/RUN/STEP/BKPT
  - state encodings ST_IDLE/RUN/DONE
- One sub-module cpu_bkpt_match:
  - parameters NBKPT, PC_W
  - inputs i_pc, i_bkpt_addr, i_bkpt_en
  - output is the NBKPT-bit combinational match vector
- FSM, counters and trace stay in cpu_run_ctrl.

Test Plan:
- Reset asserted mid-run in mode 01 -> o_cpu_en=0 immediately (before the next edge); o_state=00, o_cycles=0.
- Mode 10, i_step_n=5, go -> o_cpu_en high exactly 5 cycles; o_done pulse one cycle later; o_cycles=5. Repeat with i_step_n=0 -> 1 cycle.
- Mode 11, bkpt0=0x10 enabled, PC incrementing from 0x0C by 1 per enable -> enables at PCs 0x0C–0x0F; o_cpu_en low when PC=0x10; o_hit=01; o_cycles=4. Re-go from PC 0x10 -> first cycle executes (no immediate stop).
- Mode 01, i_stop at 100th enabled cycle -> o_cpu_en low that cycle; o_cycles=99; o_done next edge. i_go while busy is ignored.
- Mode 00 go -> o_done pulse, o_cpu_en never high, o_cycles=0. Counter with CNT_W=4 over 20 cycles saturates at 15.
- CPU_RUN_TRACE_EN, 10 steps over PCs 1..10 -> idx0=10, idx7=3; wrap verified.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared encodings for the CPU run/step controller.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_BKPT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: control, status and debug signals of the run/step controller.
// master = board/testbench side, slave = controller side.
interface cpu_run_ctrl_if #(
  parameter int PC_W        = 8,
  parameter int CNT_W       = 32,
  parameter int STEP_W      = 16,
  parameter int NBKPT       = 2,
  parameter int TRACE_DEPTH = 8
);
  localparam int IDX_W = $clog2(TRACE_DEPTH);

  logic [1:0]           i_mode;
  logic                 i_go;
  logic [STEP_W-1:0]    i_step_n;
  logic                 i_stop;
  logic [PC_W-1:0]      i_pc;
  logic [NBKPT*PC_W-1:0] i_bkpt_addr;
  logic [NBKPT-1:0]     i_bkpt_en;
  logic [IDX_W-1:0]     i_trace_idx;
  logic                 o_cpu_en;
  logic                 o_busy;
  logic                 o_done;
  logic [NBKPT-1:0]     o_hit;
  logic [CNT_W-1:0]     o_cycles;
  logic [1:0]           o_state;
  logic [PC_W-1:0]      o_trace_pc;

  modport master (
    output i_mode, i_go, i_step_n, i_stop, i_pc, i_bkpt_addr, i_bkpt_en, i_trace_idx,
    input  o_cpu_en, o_busy, o_done, o_hit, o_cycles, o_state, o_trace_pc
  );

  modport slave (
    input  i_mode, i_go, i_step_n, i_stop, i_pc, i_bkpt_addr, i_bkpt_en, i_trace_idx,
    output o_cpu_en, o_busy, o_done, o_hit, o_cycles, o_state, o_trace_pc
  );

endinterface

// File: rtl/cpu_bkpt_match.sv
// cpu_bkpt_match: combinational comparison of the CPU PC against each enabled breakpoint.
module cpu_bkpt_match #(
  parameter int NBKPT = 2,
  parameter int PC_W  = 8
) (
  input  logic [PC_W-1:0]       i_pc,
  input  logic [NBKPT*PC_W-1:0] i_bkpt_addr,
  input  logic [NBKPT-1:0]      i_bkpt_en,
  output logic [NBKPT-1:0]      o_match
);

  // One match bit per breakpoint slot, gated by its enable.
  always_comb begin
    o_match = '0;
    for (int k = 0; k < NBKPT; k++) begin
      if (i_bkpt_en[k] && (i_bkpt_addr[k*PC_W +: PC_W] == i_pc)) begin
        o_match[k] = 1'b1;
      end else begin
        o_match[k] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint controller producing the CPU clock enable.
// Optional PC trace buffer is built when CPU_RUN_TRACE_EN is defined;
// otherwise o_trace_pc reads 0.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int CNT_W       = 32,
  parameter int STEP_W      = 16,
  parameter int NBKPT       = 2,
  parameter int TRACE_DEPTH = 8
) (
  input logic           clk,
  input logic           reset,
  cpu_run_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(TRACE_DEPTH);

  state_e             r_state;
  state_e             w_state_nxt;
  mode_e              r_mode;
  logic [STEP_W-1:0]  r_step;
  logic               r_first;
  logic [CNT_W-1:0]   r_cycles;
  logic [NBKPT-1:0]   r_hit;
  logic [NBKPT-1:0]   w_match;
  logic [NBKPT-1:0]   w_hit_vec;
  logic               w_stop;
  logic               w_cpu_en;
  logic               w_go_ok;
  logic [PC_W-1:0]    w_trace_pc;

  cpu_bkpt_match #(.NBKPT(NBKPT), .PC_W(PC_W)) u_bkpt (
    .i_pc        (bus.i_pc),
    .i_bkpt_addr (bus.i_bkpt_addr),
    .i_bkpt_en   (bus.i_bkpt_en),
    .o_match     (w_match)
  );

  // Stop condition in RUN; breakpoints are ignored on the first cycle so a resume from a breakpoint PC makes progress.
  always_comb begin
    w_stop    = 1'b0;
    w_hit_vec = '0;
    if (r_state == ST_RUN) begin
      if ((r_mode == MODE_BKPT) && !r_first) begin
        w_hit_vec = w_match;
      end else begin
        w_hit_vec = '0;
      end
      w_stop = bus.i_stop || (|w_hit_vec) ||
               ((r_mode == MODE_STEP) && (r_step == '0));
    end else begin
      w_stop    = 1'b0;
      w_hit_vec = '0;
    end
  end

  assign w_cpu_en = (r_state == ST_RUN) && !w_stop;

  // Next-state logic: go is honoured only in IDLE; DONE always lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_go_ok     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_go) begin
          w_go_ok     = 1'b1;
          w_state_nxt = (mode_e'(bus.i_mode) == MODE_HALT) ? ST_DONE : ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_stop) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Run context: latched mode, step budget, first-cycle flag, cycle counter and sticky hit vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode   <= MODE_HALT;
      r_step   <= '0;
      r_first  <= 1'b0;
      r_cycles <= '0;
      r_hit    <= '0;
    end else if (w_go_ok) begin
      r_mode   <= mode_e'(bus.i_mode);
      r_step   <= (bus.i_step_n == '0) ? STEP_W'(1) : bus.i_step_n;
      r_first  <= 1'b1;
      r_cycles <= '0;
      r_hit    <= '0;
    end else if (w_cpu_en) begin
      r_first  <= 1'b0;
      r_cycles <= (r_cycles == {CNT_W{1'b1}}) ? r_cycles : r_cycles + CNT_W'(1);
      r_step   <= (r_step == '0) ? r_step : r_step - STEP_W'(1);
    end else if (w_stop) begin
      r_hit    <= w_hit_vec;
    end
  end

`ifdef CPU_RUN_TRACE_EN
  logic [PC_W-1:0]  r_trace [TRACE_DEPTH];
  logic [IDX_W-1:0] r_wptr;
  logic [IDX_W-1:0] w_rd_idx;

  // Circular PC history, one entry per executed cycle; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        r_trace[i] <= '0;
      end
      r_wptr <= '0;
    end else if (w_cpu_en) begin
      r_trace[r_wptr] <= bus.i_pc;
      r_wptr          <= r_wptr + IDX_W'(1);
    end
  end

  // Index 0 is the most recent write; modulo wrap comes from the pointer width.
  assign w_rd_idx   = r_wptr - IDX_W'(1) - bus.i_trace_idx;
  assign w_trace_pc = r_trace[w_rd_idx];
`else
  logic w_unused_trace_idx;
  assign w_unused_trace_idx = ^bus.i_trace_idx;
  assign w_trace_pc         = '0;
`endif

  assign bus.o_cpu_en   = w_cpu_en;
  assign bus.o_busy     = (r_state == ST_RUN);
  assign bus.o_done     = (r_state == ST_DONE);
  assign bus.o_hit      = r_hit;
  assign bus.o_cycles   = r_cycles;
  assign bus.o_state    = r_state;
  assign bus.o_trace_pc = w_trace_pc;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed vectors for cpu_run_ctrl with hand-computed expectations.
module tb_cpu_run_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  int          en_cnt, done_k, done_cnt, first_en_k, busy_at_go;
  logic [31:0] cyc_done, hit_done, st_done;

  cpu_run_ctrl_if #(.CNT_W(32)) bus ();
  cpu_run_ctrl_if #(.CNT_W(4))  bus4 ();

  cpu_run_ctrl #(.CNT_W(32)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
  cpu_run_ctrl #(.CNT_W(4))  u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expct);
    n_vec++;
    if (obs !== expct) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expct);
    end
  endtask

  // One clock; the bench plays the CPU and advances PC after every enabled cycle.
  task automatic cyc();
    logic en;
    en = bus.o_cpu_en;
    @(posedge clk);
    #1;
    if (en) bus.i_pc = bus.i_pc + 8'd1;
  endtask

  task automatic run(input logic [1:0] mode, input logic [15:0] n, input int nmax,
                     input int stop_k, input int go_k);
    en_cnt = 0; done_k = 0; done_cnt = 0; first_en_k = 0; busy_at_go = 0;
    cyc_done = 32'hdead; hit_done = 32'hdead; st_done = 32'hdead;
    bus.i_mode = mode; bus.i_step_n = n; bus.i_go = 1'b1;
    for (int k = 1; k <= nmax; k++) begin
      cyc();
      bus.i_go   = (k == go_k);
      bus.i_stop = (k == stop_k);
      if (k == 1) bus.i_mode = 2'b01;
      #2;
      if (k == go_k) busy_at_go = int'(bus.o_busy);
      if (bus.o_cpu_en) begin
        en_cnt++;
        if (first_en_k == 0) first_en_k = k;
      end
      if (bus.o_done) begin
        done_cnt++;
        if (done_k == 0) begin
          done_k = k; cyc_done = bus.o_cycles; hit_done = 32'(bus.o_hit); st_done = 32'(bus.o_state);
        end
      end
    end
    bus.i_go = 1'b0; bus.i_stop = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1;
    bus.i_mode = 2'b00; bus.i_go = 1'b0; bus.i_step_n = 16'd0; bus.i_stop = 1'b0;
    bus.i_pc = 8'h00; bus.i_bkpt_addr = 16'h0000; bus.i_bkpt_en = 2'b00; bus.i_trace_idx = 3'd0;
    bus4.i_mode = 2'b00; bus4.i_go = 1'b0; bus4.i_step_n = 16'd0; bus4.i_stop = 1'b0;
    bus4.i_pc = 8'h00; bus4.i_bkpt_addr = 16'h0000; bus4.i_bkpt_en = 2'b00; bus4.i_trace_idx = 3'd0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_state",  32'(bus.o_state), 32'd0);
    check("rst_cpu_en", 32'(bus.o_cpu_en), 32'd0);
    check("rst_busy",   32'(bus.o_busy), 32'd0);
    check("rst_done",   32'(bus.o_done), 32'd0);
    check("rst_hit",    32'(bus.o_hit), 32'd0);
    check("rst_cycles", bus.o_cycles, 32'd0);
    check("rst_trace0", 32'(bus.o_trace_pc), 32'd0);
    cyc();
    reset = 1'b0;

    // Step-10 over PCs 1..10: exercises the trace wrap as well.
    bus.i_pc = 8'd1;
    run(2'b10, 16'd10, 14, 0, 0);
    check("s10_en_cnt", 32'(en_cnt), 32'd10);
    check("s10_cycles", cyc_done, 32'd10);
    bus.i_trace_idx = 3'd0; #1;
`ifdef CPU_RUN_TRACE_EN
    check("trace_idx0", 32'(bus.o_trace_pc), 32'd10);
    bus.i_trace_idx = 3'd7; #1;
    check("trace_idx7", 32'(bus.o_trace_pc), 32'd3);
    bus.i_trace_idx = 3'd2; #1;
    check("trace_idx2", 32'(bus.o_trace_pc), 32'd8);
`else
    check("trace_off0", 32'(bus.o_trace_pc), 32'd0);
    bus.i_trace_idx = 3'd7; #1;
    check("trace_off7", 32'(bus.o_trace_pc), 32'd0);
`endif
    bus.i_trace_idx = 3'd0;

    // Step-5: enables on cycles 1..5, done pulse on cycle 7; mode change mid-run ignored.
    run(2'b10, 16'd5, 10, 0, 0);
    check("s5_en_cnt",   32'(en_cnt), 32'd5);
    check("s5_first_en", 32'(first_en_k), 32'd1);
    check("s5_done_k",   32'(done_k), 32'd7);
    check("s5_done_cnt", 32'(done_cnt), 32'd1);
    check("s5_cycles",   cyc_done, 32'd5);
    check("s5_state",    st_done, 32'd2);

    // Step count 0 behaves as 1.
    run(2'b10, 16'd0, 6, 0, 0);
    check("s0_en_cnt", 32'(en_cnt), 32'd1);
    check("s0_done_k", 32'(done_k), 32'd3);
    check("s0_cycles", cyc_done, 32'd1);

    // Breakpoint at 0x10 (slot 1 disabled at 0x0E): enables at PC 0x0C..0x0F.
    bus.i_pc = 8'h0C; bus.i_bkpt_addr = {8'h0E, 8'h10}; bus.i_bkpt_en = 2'b01;
    run(2'b11, 16'd0, 8, 0, 0);
    check("bk_en_cnt", 32'(en_cnt), 32'd4);
    check("bk_done_k", 32'(done_k), 32'd6);
    check("bk_cycles", cyc_done, 32'd4);
    check("bk_hit",    hit_done, 32'd1);
    check("bk_pc",     32'(bus.i_pc), 32'h10);
    check("bk_sticky", 32'(bus.o_hit), 32'd1);
    check("bk_idle",   32'(bus.o_state), 32'd0);

    // Resume from the breakpoint PC executes immediately; stop on cycle 3.
    run(2'b11, 16'd0, 6, 3, 0);
    check("rg_first_en", 32'(first_en_k), 32'd1);
    check("rg_en_cnt",   32'(en_cnt), 32'd2);
    check("rg_hit",      hit_done, 32'd0);
    bus.i_bkpt_en = 2'b00;

    // Free-run, stop at the 100th enabled cycle, stray go while busy.
    run(2'b01, 16'd0, 104, 100, 50);
    check("fr_busy_go", 32'(busy_at_go), 32'd1);
    check("fr_en_cnt",  32'(en_cnt), 32'd99);
    check("fr_cycles",  cyc_done, 32'd99);
    check("fr_done_k",  32'(done_k), 32'd101);

    // Halt mode: straight to DONE, never enables, cycles cleared.
    run(2'b00, 16'd0, 4, 0, 0);
    check("h_en_cnt", 32'(en_cnt), 32'd0);
    check("h_done_k", 32'(done_k), 32'd1);
    check("h_cycles", cyc_done, 32'd0);

    // 4-bit counter saturates at 15.
    bus4.i_mode = 2'b01; bus4.i_go = 1'b1;
    cyc();
    bus4.i_go = 1'b0;
    repeat (19) cyc();
    #2;
    check("sat_cycles", 32'(bus4.o_cycles), 32'd15);
    bus4.i_stop = 1'b1; #1;
    check("sat_stop_en", 32'(bus4.o_cpu_en), 32'd0);
    cyc();
    bus4.i_stop = 1'b0; #2;
    check("sat_done", 32'(bus4.o_done), 32'd1);
    cyc();

    // Reset mid-run drops the enable before the next edge.
    run(2'b01, 16'd0, 10, 0, 0);
    check("mr_running", 32'(bus.o_cpu_en), 32'd1);
    reset = 1'b1; #1;
    check("mr_cpu_en", 32'(bus.o_cpu_en), 32'd0);
    check("mr_state",  32'(bus.o_state), 32'd0);
    check("mr_cycles", bus.o_cycles, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
